// File: rtl/dc_job_scheduler_pkg.sv
// Shared types and constants for the accelerator job scheduler:
// FSM state encoding, opcode values, the queued job record and sizing helpers.
package dc_job_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

    localparam logic [1:0] OP_ILLEGAL = 2'b00;
    localparam logic [1:0] OP_FFT     = 2'b01;
    localparam logic [1:0] OP_FIR     = 2'b10;
    localparam logic [1:0] OP_IIR     = 2'b11;

    // One queued job as stored in the command FIFO.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] offset;
        logic [31:0] filesize;
    } job_t;

    localparam int JOB_W = $bits(job_t);

    // Only the three accelerator opcodes are runnable; 00 is dropped with an error.
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_FFT) || (op == OP_FIR) || (op == OP_IIR);
    endfunction

    // Watchdog width: wide enough for TIMEOUT-1, never narrower than 16 bits.
    function automatic int wd_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 16) ? 16 : w;
    endfunction

endpackage

// File: rtl/dc_job_scheduler_if.sv
// Host command channel plus router command/completion signals.
// master = host/router side, slave = scheduler.
interface dc_job_scheduler_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_instr;
    logic [31:0] cmd_offset;
    logic [31:0] cmd_filesize;

    logic        chipselect;
    logic [31:0] instruction;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        acc_done;

    modport master (
        output cmd_valid, cmd_instr, cmd_offset, cmd_filesize, acc_done,
        input  cmd_ready, chipselect, instruction, offset, filesize
    );

    modport slave (
        input  cmd_valid, cmd_instr, cmd_offset, cmd_filesize, acc_done,
        output cmd_ready, chipselect, instruction, offset, filesize
    );

endinterface

// File: rtl/dc_job_scheduler_cmd_fifo.sv
// Job queue: DEPTH-entry synchronous FIFO with wrap-around pointers
// (extra MSB distinguishes full from empty) and a head word visible
// combinationally so the scheduler can inspect the opcode before popping.
module dc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_reg;
    logic [AW:0]  rptr_reg;
    logic         wr_en;
    logic         rd_en;

    // A full queue refuses pushes even in a cycle that also pops.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance on accepted push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wptr_reg <= wptr_reg + (AW+1)'(1);
            end
            if (rd_en) begin
                rptr_reg <= rptr_reg + (AW+1)'(1);
            end
        end
    end

    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[AW] != rptr_reg[AW]) &&
                     (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign count   = wptr_reg - rptr_reg;
    assign rd_data = mem[rptr_reg[AW-1:0]];

endmodule

// File: rtl/dc_job_scheduler.sv
// Accelerator job scheduler: queues host jobs and issues them one at a time
// to the data/control router, holding each job's command words until the
// router reports completion or the watchdog aborts it.
module dc_job_scheduler
    import dc_job_scheduler_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    dc_job_scheduler_if.slave    bus,
    output logic                 busy,
    output logic [AW:0]          q_count,
    output logic                 job_done,
    output logic                 job_timeout,
    output logic                 job_error,
    output logic [15:0]          done_count
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_t    state_reg;
    logic [WD_W-1:0] wd_reg;
    logic [15:0]     done_count_reg;
    logic [31:0]     instruction_reg;
    logic [31:0]     offset_reg;
    logic [31:0]     filesize_reg;
    logic            chipselect_reg;
    logic            busy_reg;
    logic            job_done_reg;
    logic            job_timeout_reg;
    logic            job_error_reg;

    job_t            head;
    job_t            wr_job;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    logic            pop;
    logic            head_legal;

    assign wr_job.instr    = bus.cmd_instr;
    assign wr_job.offset   = bus.cmd_offset;
    assign wr_job.filesize = bus.cmd_filesize;

    dc_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (JOB_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.cmd_valid),
        .wr_data (wr_job),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_legal = op_is_legal(head.instr[1:0]);

    // Queue pop: illegal heads are discarded from IDLE; the active job leaves
    // the queue when it completes or is aborted (completion takes priority).
    always_comb begin
        pop = 1'b0;
        case (state_reg)
            ST_IDLE: pop = !fifo_empty && !head_legal;
            ST_RUN:  pop = bus.acc_done || (wd_reg == WD_LAST);
            default: pop = 1'b0;
        endcase
    end

    // Scheduler FSM with watchdog, completion counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            wd_reg          <= '0;
            done_count_reg  <= '0;
            instruction_reg <= '0;
            offset_reg      <= '0;
            filesize_reg    <= '0;
            chipselect_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            job_done_reg    <= 1'b0;
            job_timeout_reg <= 1'b0;
            job_error_reg   <= 1'b0;
        end else begin
            // Strobes and status pulses last a single cycle.
            chipselect_reg  <= 1'b0;
            job_done_reg    <= 1'b0;
            job_timeout_reg <= 1'b0;
            job_error_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (!head_legal) begin
                            job_error_reg <= 1'b1;
                        end else begin
                            instruction_reg <= head.instr;
                            offset_reg      <= head.offset;
                            filesize_reg    <= head.filesize;
                            chipselect_reg  <= 1'b1;
                            busy_reg        <= 1'b1;
                            state_reg       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    wd_reg    <= '0;
                    state_reg <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.acc_done) begin
                        job_done_reg    <= 1'b1;
                        done_count_reg  <= done_count_reg + 16'd1;
                        instruction_reg <= '0;
                        offset_reg      <= '0;
                        filesize_reg    <= '0;
                        state_reg       <= ST_RELEASE;
                    end else if (wd_reg == WD_LAST) begin
                        job_timeout_reg <= 1'b1;
                        instruction_reg <= '0;
                        offset_reg      <= '0;
                        filesize_reg    <= '0;
                        state_reg       <= ST_RELEASE;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Wait out a still-high acc_done so one assertion never
                    // completes two jobs.
                    if (!bus.acc_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.chipselect  = chipselect_reg;
    assign bus.instruction = instruction_reg;
    assign bus.offset      = offset_reg;
    assign bus.filesize    = filesize_reg;

    assign busy        = busy_reg;
    assign q_count     = fifo_count;
    assign job_done    = job_done_reg;
    assign job_timeout = job_timeout_reg;
    assign job_error   = job_error_reg;
    assign done_count  = done_count_reg;

endmodule

// File: tb/tb_dc_job_scheduler.sv
// Bench for dc_job_scheduler: directed scenarios plus random traffic, with a
// queue-based job model compared against the DUT on every clock.
module tb_dc_job_scheduler;

    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 16;

    logic            clk;
    logic            reset;
    logic            busy;
    logic [AW:0]     q_count;
    logic            job_done;
    logic            job_timeout;
    logic            job_error;
    logic [15:0]     done_count;

    dc_job_scheduler_if bus ();

    dc_job_scheduler #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .q_count     (q_count),
        .job_done    (job_done),
        .job_timeout (job_timeout),
        .job_error   (job_error),
        .done_count  (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Jobs waiting (including the one being worked on) live in a queue; the
    // job's life is tracked as waiting -> starting -> running -> draining.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] offset;
        logic [31:0] filesize;
    } mjob_t;

    localparam int WAITING  = 0;
    localparam int STARTING = 1;
    localparam int RUNNING  = 2;
    localparam int DRAINING = 3;

    mjob_t       mq[$];
    int          ph       = WAITING;
    int          run_age  = 0;
    logic        e_cs     = 1'b0;
    logic [31:0] e_instr  = '0;
    logic [31:0] e_off    = '0;
    logic [31:0] e_fs     = '0;
    logic        e_done   = 1'b0;
    logic        e_to     = 1'b0;
    logic        e_err    = 1'b0;
    logic [15:0] e_dc     = '0;

    task automatic model_clear();
        mq.delete();
        ph = WAITING; run_age = 0;
        e_cs = 0; e_instr = 0; e_off = 0; e_fs = 0;
        e_done = 0; e_to = 0; e_err = 0; e_dc = 0;
    endtask

    task automatic model_step();
        bit    accept;
        mjob_t nj;
        accept      = bus.cmd_valid && (mq.size() < DEPTH);
        nj.instr    = bus.cmd_instr;
        nj.offset   = bus.cmd_offset;
        nj.filesize = bus.cmd_filesize;
        e_done = 0; e_to = 0; e_err = 0; e_cs = 0;
        if (ph == WAITING) begin
            if (mq.size() != 0) begin
                if (mq[0].instr[1:0] == 2'b00) begin
                    void'(mq.pop_front());
                    e_err = 1;
                end else begin
                    e_instr = mq[0].instr; e_off = mq[0].offset; e_fs = mq[0].filesize;
                    e_cs = 1; ph = STARTING;
                end
            end
        end else if (ph == STARTING) begin
            run_age = 0; ph = RUNNING;
        end else if (ph == RUNNING) begin
            if (bus.acc_done || run_age == TIMEOUT - 1) begin
                void'(mq.pop_front());
                if (bus.acc_done) begin e_done = 1; e_dc = e_dc + 16'd1; end
                else e_to = 1;
                e_instr = 0; e_off = 0; e_fs = 0;
                ph = DRAINING;
            end else begin
                run_age++;
            end
        end else begin
            if (!bus.acc_done) ph = WAITING;
        end
        if (accept) mq.push_back(nj);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else        model_step();
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("cmd_ready",   64'(bus.cmd_ready),   64'(mq.size() < DEPTH));
            chk("q_count",     64'(q_count),         64'(mq.size()));
            chk("chipselect",  64'(bus.chipselect),  64'(e_cs));
            chk("instruction", 64'(bus.instruction), 64'(e_instr));
            chk("offset",      64'(bus.offset),      64'(e_off));
            chk("filesize",    64'(bus.filesize),    64'(e_fs));
            chk("busy",        64'(busy),            64'(ph != WAITING));
            chk("job_done",    64'(job_done),        64'(e_done));
            chk("job_timeout", 64'(job_timeout),     64'(e_to));
            chk("job_error",   64'(job_error),       64'(e_err));
            chk("done_count",  64'(done_count),      64'(e_dc));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_job(input logic [31:0] ins, input logic [31:0] off, input logic [31:0] fs);
        bus.cmd_valid    = 1'b1;
        bus.cmd_instr    = ins;
        bus.cmd_offset   = off;
        bus.cmd_filesize = fs;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid    = 1'b0;
        bus.cmd_instr    = '0;
        bus.cmd_offset   = '0;
        bus.cmd_filesize = '0;
    endtask

    function automatic logic [31:0] rand_instr(input logic [1:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:2], op};
    endfunction

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while ((busy !== 1'b0 || q_count !== '0) && n < limit) begin
            @(negedge clk); n++;
        end
        chk(nm, 64'(n < limit), 64'(1));
        $display("txn: %s reached idle after %0d cycles", nm, n);
    endtask

    task automatic wait_cs(input string nm, input int limit, output int n);
        n = 0;
        while (bus.chipselect !== 1'b1 && n < limit) begin
            @(negedge clk); n++;
        end
        chk(nm, 64'(n < limit), 64'(1));
    endtask

    task automatic finish_job(input string nm);
        int n = 0;
        bus.acc_done = 1'b1;
        while (job_done !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        chk(nm, 64'(n < 60), 64'(1));
        bus.acc_done = 1'b0;
        $display("txn: %s completed, done_count=%0d", nm, done_count);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_cs"},    64'(bus.chipselect),  64'(0));
        chk({nm, "_instr"}, 64'(bus.instruction), 64'(0));
        chk({nm, "_off"},   64'(bus.offset),      64'(0));
        chk({nm, "_fs"},    64'(bus.filesize),    64'(0));
        chk({nm, "_rdy"},   64'(bus.cmd_ready),   64'(1));
        chk({nm, "_qc"},    64'(q_count),         64'(0));
        chk({nm, "_busy"},  64'(busy),            64'(0));
        chk({nm, "_pulse"}, 64'({job_done, job_timeout, job_error}), 64'(0));
        chk({nm, "_dc"},    64'(done_count),      64'(0));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int w;
        int cs_seen;
        reset        = 1'b0;
        bus.acc_done = 1'b0;
        idle_inputs();
        #3;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: single FFT job, completion 10 cycles after chipselect
        drive_job(32'h1, 32'h100, 32'd16);
        @(negedge clk);
        idle_inputs();
        chk("t1_qc_after_push", 64'(q_count), 64'(1));
        chk("t1_no_cs_yet",     64'(bus.chipselect), 64'(0));
        @(negedge clk);
        chk("t1_cs",    64'(bus.chipselect),  64'(1));
        chk("t1_instr", 64'(bus.instruction), 64'(1));
        chk("t1_off",   64'(bus.offset),      64'(32'h100));
        chk("t1_fs",    64'(bus.filesize),    64'(16));
        @(negedge clk);
        chk("t1_cs_one_cycle", 64'(bus.chipselect),  64'(0));
        chk("t1_held",         64'(bus.instruction), 64'(1));
        repeat (9) @(negedge clk);
        bus.acc_done = 1'b1;
        @(negedge clk);
        chk("t1_job_done",   64'(job_done),        64'(1));
        chk("t1_done_count", 64'(done_count),      64'(1));
        chk("t1_released",   64'(bus.instruction), 64'(0));
        bus.acc_done = 1'b0;
        @(negedge clk);
        chk("t1_back_idle", 64'(busy), 64'(0));
        $display("txn: t1 FFT job done, done_count=%0d", done_count);

        // 2: five back-to-back pushes into a 4-deep queue, router silent
        wait_idle("t2_pre", 50);
        for (int i = 0; i < 4; i++) begin
            drive_job(rand_instr(2'(i % 3 + 1)), $urandom(), $urandom_range(1, 99));
            @(negedge clk);
        end
        chk("t2_qc_full",  64'(q_count),       64'(4));
        chk("t2_not_rdy",  64'(bus.cmd_ready), 64'(0));
        drive_job(rand_instr(2'b11), 32'h5555, 32'd5);
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk); w++;
        end
        chk("t2_ready_wait", 64'(w), 64'(15));
        chk("t2_timeout",    64'(job_timeout), 64'(1));
        @(negedge clk);
        idle_inputs();
        chk("t2_refilled", 64'(q_count), 64'(4));
        $display("txn: t2 fifth job accepted after %0d stalled cycles", w);
        wait_idle("t2_drain", 200);
        chk("t2_dc_unchanged", 64'(done_count), 64'(1));

        // 3: illegal opcode dropped, FIR job issued next
        drive_job(32'h0, 32'h200, 32'd4);
        @(negedge clk);
        drive_job(32'h2, 32'h300, 32'd8);
        @(negedge clk);
        idle_inputs();
        chk("t3_error",    64'(job_error),      64'(1));
        chk("t3_no_cs",    64'(bus.chipselect), 64'(0));
        @(negedge clk);
        chk("t3_fir_cs",   64'(bus.chipselect),  64'(1));
        chk("t3_fir_ins",  64'(bus.instruction), 64'(2));
        chk("t3_fir_off",  64'(bus.offset),      64'(32'h300));
        finish_job("t3_fir");
        wait_idle("t3_post", 50);

        // 5: acc_done held after completion blocks the next issue
        drive_job(32'h3, 32'h40, 32'd1);
        @(negedge clk);
        drive_job(32'h1, 32'h80, 32'd2);
        @(negedge clk);
        idle_inputs();
        wait_cs("t5_first_cs", 20, w);
        bus.acc_done = 1'b1;
        w = 0;
        while (job_done !== 1'b1 && w < 40) begin
            @(negedge clk); w++;
        end
        chk("t5_done_seen", 64'(w < 40), 64'(1));
        cs_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.chipselect === 1'b1) cs_seen++;
        end
        chk("t5_no_cs_while_high", 64'(cs_seen), 64'(0));
        chk("t5_still_busy",       64'(busy),    64'(1));
        bus.acc_done = 1'b0;
        wait_cs("t5_second_cs", 20, w);
        chk("t5_cs_latency", 64'(w),               64'(2));
        chk("t5_second_ins", 64'(bus.instruction), 64'(1));
        finish_job("t5_second");
        wait_idle("t5_post", 50);

        // Random traffic, including illegal opcodes and stray acc_done pulses
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid    = ($urandom_range(0, 2) == 0);
            bus.cmd_instr    = rand_instr(2'($urandom_range(0, 3)));
            bus.cmd_offset   = $urandom();
            bus.cmd_filesize = $urandom_range(0, 4096);
            bus.acc_done     = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            if (job_done === 1'b1 || job_timeout === 1'b1 || job_error === 1'b1)
                $display("txn: rand cycle %0d done=%0b timeout=%0b error=%0b count=%0d",
                         i, job_done, job_timeout, job_error, done_count);
        end
        idle_inputs();
        bus.acc_done = 1'b0;
        wait_idle("rand_drain", 500);

        // 6: asynchronous reset during RUN with three jobs queued
        for (int i = 0; i < 3; i++) begin
            drive_job(rand_instr(2'b01), $urandom(), 32'd7);
            @(negedge clk);
        end
        idle_inputs();
        chk("t6_qc", 64'(q_count), 64'(3));
        @(negedge clk);
        chk("t6_running", 64'(busy), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_quiet", 64'({job_done, job_timeout, job_error, bus.chipselect}), 64'(0));
        end
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_empty_after", 64'(q_count), 64'(0));
        chk("t6_idle_after",  64'(busy),    64'(0));
        $display("txn: t6 reset mid-job, q_count=%0d", q_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time guard.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
